loop_counter: RTL and testbench

- Parametrised iteration counter for the multiplier control path, replacing the fixed 3-bit load-to-4 down-counter.
- Adds configurable width, reload value and step, plus runtime load, increment, and wrap or saturate mode.
- Provides an optional edge-detect on the count requests, zero/done/error flags for the sequencer FSM.

---
 rtl/loop_counter.sv | 114 +++++++++++
 tb/tb_loop_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/loop_counter.sv
// loop_counter: parametrised up/down iteration counter for the multiplier
// control path, with wrap or saturate mode, optional edge-detected requests
// and zero/done/underflow/overflow flags for the sequencer.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, count -> 0
//   RESET       synchronous reload of INIT
//   LOAD        synchronous load of LOAD_VALUE
//   LOAD_VALUE  value for LOAD
//   DECREMENT   count-down request
//   INCREMENT   count-up request
//   count       registered count
//   ZERO        count == 0
//   DONE        one-cycle pulse when a decrement lands on 0
//   UNDERFLOW   sticky, decrement with count < STEP
//   OVERFLOW    sticky, increment with count > max-STEP
module loop_counter #(
  parameter int WIDTH     = 3,
  parameter int INIT      = 4,
  parameter int STEP      = 1,
  parameter int WRAP      = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             DECREMENT,
  input  logic             INCREMENT,
  output logic [WIDTH-1:0] count,
  output logic             ZERO,
  output logic             DONE,
  output logic             UNDERFLOW,
  output logic             OVERFLOW
);

  localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];
  localparam logic [WIDTH:0]   STEP_W = STEP[WIDTH:0];

  logic             dec_prev;
  logic             inc_prev;
  logic             dec_ev;
  logic             inc_ev;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] cnt_n;
  logic             done_n;
  logic             uf_n;
  logic             of_n;

  // In edge mode a request only counts on its 0->1 transition.
  assign dec_ev = DECREMENT & ((EDGE_MODE == 0) | ~dec_prev);
  assign inc_ev = INCREMENT & ((EDGE_MODE == 0) | ~inc_prev);

  // One extra bit: diff[WIDTH] is the borrow, sum[WIDTH] the carry.
  assign diff = {1'b0, count} - STEP_W;
  assign sum  = {1'b0, count} + STEP_W;

  assign ZERO = (count == '0);

  always_comb begin
    cnt_n  = count;
    done_n = 1'b0;
    uf_n   = UNDERFLOW;
    of_n   = OVERFLOW;
    if (RESET) begin
      cnt_n = INIT_W;
      uf_n  = 1'b0;
      of_n  = 1'b0;
    end else if (LOAD) begin
      cnt_n = LOAD_VALUE;
      uf_n  = 1'b0;
      of_n  = 1'b0;
    end else if (dec_ev && inc_ev) begin
      cnt_n = count;
    end else if (dec_ev) begin
      if (diff[WIDTH]) begin
        uf_n  = 1'b1;
        cnt_n = (WRAP != 0) ? diff[WIDTH-1:0] : '0;
      end else begin
        cnt_n = diff[WIDTH-1:0];
      end
      done_n = (count != '0) && (cnt_n == '0);
    end else if (inc_ev) begin
      if (sum[WIDTH]) begin
        of_n  = 1'b1;
        cnt_n = (WRAP != 0) ? sum[WIDTH-1:0] : '1;
      end else begin
        cnt_n = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      DONE      <= 1'b0;
      UNDERFLOW <= 1'b0;
      OVERFLOW  <= 1'b0;
      dec_prev  <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      count     <= cnt_n;
      DONE      <= done_n;
      UNDERFLOW <= uf_n;
      OVERFLOW  <= of_n;
      dec_prev  <= DECREMENT;
      inc_prev  <= INCREMENT;
    end
  end

endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: directed bench for loop_counter across five
// parameter sets sharing one stimulus stream.
module tb_loop_counter;

  logic       clk;
  logic       reset;
  logic       RESET;
  logic       LOAD;
  logic [2:0] lv;
  logic       dec;
  logic       inc;

  logic [4:0][2:0] cnt;
  logic [4:0]      z;
  logic [4:0]      dn;
  logic [4:0]      uf;
  logic [4:0]      of;

  int checks = 0;
  int errors = 0;

  // 0: defaults, 1: wrap, 2: edge mode, 3: step 2 sat, 4: step 2 wrap
  loop_counter #(.WIDTH(3), .INIT(4), .STEP(1), .WRAP(0), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .RESET(RESET), .LOAD(LOAD),
    .LOAD_VALUE(lv), .DECREMENT(dec), .INCREMENT(inc),
    .count(cnt[0]), .ZERO(z[0]), .DONE(dn[0]),
    .UNDERFLOW(uf[0]), .OVERFLOW(of[0]));

  loop_counter #(.WIDTH(3), .INIT(4), .STEP(1), .WRAP(1), .EDGE_MODE(0)) u1 (
    .clk(clk), .reset(reset), .RESET(RESET), .LOAD(LOAD),
    .LOAD_VALUE(lv), .DECREMENT(dec), .INCREMENT(inc),
    .count(cnt[1]), .ZERO(z[1]), .DONE(dn[1]),
    .UNDERFLOW(uf[1]), .OVERFLOW(of[1]));

  loop_counter #(.WIDTH(3), .INIT(4), .STEP(1), .WRAP(0), .EDGE_MODE(1)) u2 (
    .clk(clk), .reset(reset), .RESET(RESET), .LOAD(LOAD),
    .LOAD_VALUE(lv), .DECREMENT(dec), .INCREMENT(inc),
    .count(cnt[2]), .ZERO(z[2]), .DONE(dn[2]),
    .UNDERFLOW(uf[2]), .OVERFLOW(of[2]));

  loop_counter #(.WIDTH(3), .INIT(4), .STEP(2), .WRAP(0), .EDGE_MODE(0)) u3 (
    .clk(clk), .reset(reset), .RESET(RESET), .LOAD(LOAD),
    .LOAD_VALUE(lv), .DECREMENT(dec), .INCREMENT(inc),
    .count(cnt[3]), .ZERO(z[3]), .DONE(dn[3]),
    .UNDERFLOW(uf[3]), .OVERFLOW(of[3]));

  loop_counter #(.WIDTH(3), .INIT(4), .STEP(2), .WRAP(1), .EDGE_MODE(0)) u4 (
    .clk(clk), .reset(reset), .RESET(RESET), .LOAD(LOAD),
    .LOAD_VALUE(lv), .DECREMENT(dec), .INCREMENT(inc),
    .count(cnt[4]), .ZERO(z[4]), .DONE(dn[4]),
    .UNDERFLOW(uf[4]), .OVERFLOW(of[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; RESET = 1'b0; LOAD = 1'b0;
    lv = 3'd0; dec = 1'b0; inc = 1'b0;

    // reset, then reload INIT
    tick();
    chk("rst_cnt", cnt[0], 0);
    chk("rst_zero", z[0], 1);
    chk("rst_done", dn[0], 0);
    chk("rst_uf", uf[0], 0);
    chk("rst_of", of[0], 0);
    reset = 1'b0; RESET = 1'b1;
    tick();
    chk("init_cnt", cnt[0], 4);
    chk("init_zero", z[0], 0);

    // level-mode countdown
    RESET = 1'b0; dec = 1'b1;
    tick(); chk("lvl_c3", cnt[0], 3); chk("lvl_d3", dn[0], 0);
    tick(); chk("lvl_c2", cnt[0], 2); chk("lvl_d2", dn[0], 0);
    tick(); chk("lvl_c1", cnt[0], 1); chk("lvl_d1", dn[0], 0);
    tick(); chk("lvl_c0", cnt[0], 0); chk("lvl_d0", dn[0], 1);
    chk("lvl_z0", z[0], 1);
    dec = 1'b0;
    tick();
    chk("lvl_done_off", dn[0], 0);
    chk("lvl_zero_hold", z[0], 1);

    // underflow at 0
    dec = 1'b1;
    tick();
    chk("uf_sat_cnt", cnt[0], 0);
    chk("uf_sat_flag", uf[0], 1);
    chk("uf_sat_done", dn[0], 0);
    chk("uf_wrap_cnt", cnt[1], 7);
    chk("uf_wrap_flag", uf[1], 1);
    dec = 1'b0; LOAD = 1'b1; lv = 3'd5;
    tick();
    chk("load_cnt", cnt[0], 5);
    chk("load_uf_clr", uf[0], 0);
    chk("load_uf_clr_w", uf[1], 0);

    // edge mode
    LOAD = 1'b0; RESET = 1'b1;
    tick();
    RESET = 1'b0; dec = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("edge_held", cnt[2], 3);
    dec = 1'b0;
    tick();
    chk("edge_drop", cnt[2], 3);
    dec = 1'b1;
    tick();
    chk("edge_rise", cnt[2], 2);
    dec = 1'b0;

    // simultaneous events on the default instance
    LOAD = 1'b1; lv = 3'd2;
    tick();
    chk("sim_ld2", cnt[0], 2);
    LOAD = 1'b0; RESET = 1'b1; dec = 1'b1;
    tick();
    chk("sim_reset_dec", cnt[0], 4);
    RESET = 1'b0; inc = 1'b1; dec = 1'b1;
    tick();
    chk("sim_incdec_cnt", cnt[0], 4);
    chk("sim_incdec_uf", uf[0], 0);
    chk("sim_incdec_of", of[0], 0);
    chk("sim_incdec_done", dn[0], 0);
    LOAD = 1'b1; lv = 3'd6; dec = 1'b0; inc = 1'b1;
    tick();
    chk("sim_load_inc", cnt[0], 6);
    lv = 3'd4; inc = 1'b0;
    tick();
    LOAD = 1'b0; dec = 1'b1;
    tick();
    chk("run_c3", cnt[0], 3);
    reset = 1'b1;
    tick();
    chk("rst_run_cnt", cnt[0], 0);
    chk("rst_run_done", dn[0], 0);

    // increment held across reset release counts once in edge mode
    dec = 1'b0; inc = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("edge_rst_1", cnt[2], 1);
    chk("lvl_rst_1", cnt[0], 1);
    tick();
    chk("edge_rst_hold", cnt[2], 1);
    chk("lvl_rst_2", cnt[0], 2);

    // STEP=2
    inc = 1'b0; LOAD = 1'b1; lv = 3'd7;
    tick();
    chk("s2_ld7", cnt[3], 7);
    LOAD = 1'b0; inc = 1'b1;
    tick();
    chk("s2_of_cnt", cnt[3], 7);
    chk("s2_of_flag", of[3], 1);
    chk("s2w_of_cnt", cnt[4], 1);
    chk("s2w_of_flag", of[4], 1);
    inc = 1'b0; LOAD = 1'b1; lv = 3'd1;
    tick();
    chk("s2_ld1", cnt[3], 1);
    chk("s2_of_clr", of[3], 0);
    LOAD = 1'b0; dec = 1'b1;
    tick();
    chk("s2_uf_cnt", cnt[3], 0);
    chk("s2_uf_flag", uf[3], 1);
    chk("s2_uf_done", dn[3], 1);
    chk("s2w_uf_cnt", cnt[4], 7);
    chk("s2w_uf_flag", uf[4], 1);
    chk("s2w_uf_done", dn[4], 0);
    dec = 1'b0;
    tick();
    chk("s2_done_off", dn[3], 0);
    chk("s2_uf_sticky", uf[3], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
